// File: rtl/factorial_sequencer.sv
// Computes n! mod 2^WIDTH by steering an external combinational ALU (ADD/XOR only).
// Latency n^2+3n-3 cycles from start (n>=1); start is ignored while busy.
module factorial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_co,
  input  logic             alu_z
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_XOR = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHK  = 3'd1,
    MADD = 3'd2,
    MDEC = 3'd3,
    KDEC = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] k, c, p, r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHK;
      CHK:     state_nxt = alu_z ? DONE : MADD;
      MADD:    state_nxt = MDEC;
      MDEC:    state_nxt = alu_z ? KDEC : MADD;
      KDEC:    state_nxt = CHK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = SEL_AND;
    busy    = (state != IDLE);
    done    = (state == DONE);
    case (state)
      CHK: begin
        alu_a   = k;
        alu_b   = ONE;
        alu_sel = SEL_XOR;
      end
      MADD: begin
        alu_a   = p;
        alu_b   = r;
        alu_sel = SEL_ADD;
      end
      MDEC: begin
        alu_a   = c;
        alu_b   = ONES;
        alu_sel = SEL_ADD;
      end
      KDEC: begin
        alu_a   = k;
        alu_b   = ONES;
        alu_sel = SEL_ADD;
      end
      default: ;
    endcase
  end

  // result is loaded on the edge entering DONE so it is valid alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      c      <= '0;
      p      <= '0;
      r      <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k   <= (n_in == '0) ? ONE : n_in;
          r   <= ONE;
          ovf <= 1'b0;
        end
        CHK: begin
          if (alu_z) begin
            result <= r;
          end else begin
            p <= '0;
            c <= k;
          end
        end
        MADD: begin
          p <= alu_out;
          if (alu_co) ovf <= 1'b1;
        end
        MDEC: c <= alu_out;
        KDEC: begin
          k <= alu_out;
          r <= p;
        end
        default: ;
      endcase
    end
  end

endmodule
